// File: rtl/vc_class_router.sv
// Class/destination router: per-class VC FIFOs feed per-destination FIFOs through a
// single-grant arbiter (strict priority or round-robin); consumers pop each destination.
module vc_class_router #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_VC     = 2,
    parameter int NUM_DEST   = 2,
    parameter int VC_DEPTH   = 8,
    parameter int D_DEPTH    = 4,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic [$clog2(NUM_VC)-1:0]      class_in,
    input  logic [$clog2(NUM_DEST)-1:0]    dest_in,
    input  logic [NUM_DEST-1:0]            pop,
    input  logic                           arb_mode,
    input  logic [CNT_WIDTH-1:0]           af_vc,
    input  logic [CNT_WIDTH-1:0]           ae_vc,
    input  logic [CNT_WIDTH-1:0]           af_d,
    input  logic [CNT_WIDTH-1:0]           ae_d,
    output logic [NUM_DEST*DATA_WIDTH-1:0] data_out,
    output logic [NUM_DEST-1:0]            valid_out,
    output logic [NUM_VC-1:0]              vc_empty,
    output logic [NUM_VC-1:0]              vc_almost_full,
    output logic [NUM_VC-1:0]              vc_almost_empty,
    output logic [NUM_DEST-1:0]            d_empty,
    output logic [NUM_DEST-1:0]            d_almost_full,
    output logic [NUM_DEST-1:0]            d_almost_empty,
    output logic [7:0]                     drop_count
);
    localparam int CLS_W = $clog2(NUM_VC);
    localparam int DST_W = $clog2(NUM_DEST);
    localparam int VC_AW = $clog2(VC_DEPTH);
    localparam int D_AW  = $clog2(D_DEPTH);
    localparam int EW    = DST_W + DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] VC_FULL = CNT_WIDTH'(VC_DEPTH);
    localparam logic [CNT_WIDTH-1:0] D_FULL  = CNT_WIDTH'(D_DEPTH);

    logic [EW-1:0]         vc_mem [NUM_VC][VC_DEPTH];
    logic [DATA_WIDTH-1:0] d_mem  [NUM_DEST][D_DEPTH];

    logic [VC_AW-1:0]     vc_wr_q [NUM_VC];
    logic [VC_AW-1:0]     vc_wr_d [NUM_VC];
    logic [VC_AW-1:0]     vc_rd_q [NUM_VC];
    logic [VC_AW-1:0]     vc_rd_d [NUM_VC];
    logic [CNT_WIDTH-1:0] vc_cnt_q [NUM_VC];
    logic [CNT_WIDTH-1:0] vc_cnt_d [NUM_VC];
    logic [D_AW-1:0]      d_wr_q [NUM_DEST];
    logic [D_AW-1:0]      d_wr_d [NUM_DEST];
    logic [D_AW-1:0]      d_rd_q [NUM_DEST];
    logic [D_AW-1:0]      d_rd_d [NUM_DEST];
    logic [CNT_WIDTH-1:0] d_cnt_q [NUM_DEST];
    logic [CNT_WIDTH-1:0] d_cnt_d [NUM_DEST];

    logic [CLS_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_DEST*DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [NUM_DEST-1:0]            valid_out_q, valid_out_d;
    logic [7:0]                     drop_count_q, drop_count_d;

    logic [DST_W-1:0]      head_dest [NUM_VC];
    logic [NUM_VC-1:0]     eligible;
    logic                  gnt_valid;
    logic [CLS_W-1:0]      gnt_idx;
    logic [CLS_W-1:0]      cand;
    logic [DST_W-1:0]      gnt_dest;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  push_ok;
    logic [NUM_VC-1:0]     vc_we;
    logic [NUM_DEST-1:0]   d_we;
    logic [NUM_DEST-1:0]   pop_ok;

    // A VC may move only if its head's destination is below af_d; the D_FULL term
    // protects the destination FIFO when af_d is programmed above its depth.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            head_dest[v] = vc_mem[v][vc_rd_q[v]][EW-1:DATA_WIDTH];
            eligible[v]  = (vc_cnt_q[v] != '0) &&
                           (d_cnt_q[head_dest[v]] < af_d) &&
                           (d_cnt_q[head_dest[v]] < D_FULL);
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (!arb_mode) begin
            for (int v = NUM_VC-1; v >= 0; v--) begin
                if (eligible[v]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = CLS_W'(v);
                end
            end
        end else begin
            for (int i = NUM_VC-1; i >= 0; i--) begin
                cand = rr_ptr_q + CLS_W'(i);
                if (eligible[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
        rr_ptr_d = (arb_mode && gnt_valid) ? gnt_idx + CLS_W'(1) : rr_ptr_q;
        gnt_dest = head_dest[gnt_idx];
        gnt_data = vc_mem[gnt_idx][vc_rd_q[gnt_idx]][DATA_WIDTH-1:0];
    end

    always_comb begin
        push_ok      = push && (vc_cnt_q[class_in] < VC_FULL);
        drop_count_d = drop_count_q;
        if (push && !push_ok && drop_count_q != 8'hFF)
            drop_count_d = drop_count_q + 8'd1;

        for (int v = 0; v < NUM_VC; v++) begin
            vc_we[v]    = push_ok && (class_in == CLS_W'(v));
            vc_wr_d[v]  = vc_we[v] ? vc_wr_q[v] + VC_AW'(1) : vc_wr_q[v];
            vc_rd_d[v]  = vc_rd_q[v];
            vc_cnt_d[v] = vc_cnt_q[v];
            if (gnt_valid && gnt_idx == CLS_W'(v))
                vc_rd_d[v] = vc_rd_q[v] + VC_AW'(1);
            case ({vc_we[v], gnt_valid && gnt_idx == CLS_W'(v)})
                2'b10:   vc_cnt_d[v] = vc_cnt_q[v] + CNT_WIDTH'(1);
                2'b01:   vc_cnt_d[v] = vc_cnt_q[v] - CNT_WIDTH'(1);
                default: vc_cnt_d[v] = vc_cnt_q[v];
            endcase
        end

        data_out_d  = data_out_q;
        valid_out_d = '0;
        for (int d = 0; d < NUM_DEST; d++) begin
            d_we[d]   = gnt_valid && (gnt_dest == DST_W'(d));
            pop_ok[d] = pop[d] && (d_cnt_q[d] != '0);
            d_wr_d[d] = d_we[d] ? d_wr_q[d] + D_AW'(1) : d_wr_q[d];
            d_rd_d[d] = pop_ok[d] ? d_rd_q[d] + D_AW'(1) : d_rd_q[d];
            case ({d_we[d], pop_ok[d]})
                2'b10:   d_cnt_d[d] = d_cnt_q[d] + CNT_WIDTH'(1);
                2'b01:   d_cnt_d[d] = d_cnt_q[d] - CNT_WIDTH'(1);
                default: d_cnt_d[d] = d_cnt_q[d];
            endcase
            if (pop_ok[d]) begin
                data_out_d[d*DATA_WIDTH +: DATA_WIDTH] = d_mem[d][d_rd_q[d]];
                valid_out_d[d] = 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++)
            if (vc_we[v]) vc_mem[v][vc_wr_q[v]] <= {dest_in, data_in};
        for (int d = 0; d < NUM_DEST; d++)
            if (d_we[d]) d_mem[d][d_wr_q[d]] <= gnt_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                vc_wr_q[v]  <= '0;
                vc_rd_q[v]  <= '0;
                vc_cnt_q[v] <= '0;
            end
            for (int d = 0; d < NUM_DEST; d++) begin
                d_wr_q[d]  <= '0;
                d_rd_q[d]  <= '0;
                d_cnt_q[d] <= '0;
            end
            rr_ptr_q     <= '0;
            data_out_q   <= '0;
            valid_out_q  <= '0;
            drop_count_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                vc_wr_q[v]  <= vc_wr_d[v];
                vc_rd_q[v]  <= vc_rd_d[v];
                vc_cnt_q[v] <= vc_cnt_d[v];
            end
            for (int d = 0; d < NUM_DEST; d++) begin
                d_wr_q[d]  <= d_wr_d[d];
                d_rd_q[d]  <= d_rd_d[d];
                d_cnt_q[d] <= d_cnt_d[d];
            end
            rr_ptr_q     <= rr_ptr_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_empty[v]        = (vc_cnt_q[v] == '0);
            vc_almost_full[v]  = (vc_cnt_q[v] >= af_vc);
            vc_almost_empty[v] = (vc_cnt_q[v] <= ae_vc);
        end
        for (int d = 0; d < NUM_DEST; d++) begin
            d_empty[d]        = (d_cnt_q[d] == '0);
            d_almost_full[d]  = (d_cnt_q[d] >= af_d);
            d_almost_empty[d] = (d_cnt_q[d] <= ae_d);
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_vc_class_router.sv
// Directed bench for vc_class_router: reset values, latency, arbitration order,
// overflow/drop saturation, empty pops and mid-operation reset.
module tb_vc_class_router;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic [7:0]  data_in = '0;
    logic        class_in = 1'b0;
    logic        dest_in = 1'b0;
    logic [1:0]  pop = '0;
    logic        arb_mode = 1'b0;
    logic [4:0]  af_vc = 5'd6, ae_vc = 5'd1, af_d = 5'd3, ae_d = 5'd0;
    logic [15:0] data_out;
    logic [1:0]  valid_out;
    logic [1:0]  vc_empty, vc_almost_full, vc_almost_empty;
    logic [1:0]  d_empty, d_almost_full, d_almost_empty;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    vc_class_router dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in),
        .class_in(class_in), .dest_in(dest_in), .pop(pop), .arb_mode(arb_mode),
        .af_vc(af_vc), .ae_vc(ae_vc), .af_d(af_d), .ae_d(ae_d),
        .data_out(data_out), .valid_out(valid_out),
        .vc_empty(vc_empty), .vc_almost_full(vc_almost_full), .vc_almost_empty(vc_almost_empty),
        .d_empty(d_empty), .d_almost_full(d_almost_full), .d_almost_empty(d_almost_empty),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d, input logic c, input logic t);
        push = 1'b1; data_in = d; class_in = c; dest_in = t;
        tick();
        push = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Drain destination 0 and compare each delivered word against exp_q.
    task automatic drain_d0(input string tag);
        pop = 2'b01;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_out[0]) begin
                if (exp_q.size() > 0) check(tag, data_out[7:0], exp_q.pop_front());
                else check({tag, "_extra"}, data_out[7:0], 32'hFFFF_FFFF);
            end
            if (valid_out[1]) check({tag, "_d1_idle"}, valid_out, 2'b01);
        end
        check({tag, "_left"}, exp_q.size(), 0);
        pop = 2'b00;
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_vc_empty", vc_empty, 2'b11);
        check("rst_d_empty", d_empty, 2'b11);
        check("rst_vc_ae", vc_almost_empty, 2'b11);
        check("rst_d_ae", d_almost_empty, 2'b11);
        check("rst_vc_af", vc_almost_full, 2'b00);
        check("rst_d_af", d_almost_full, 2'b00);
        check("rst_valid", valid_out, 2'b00);
        check("rst_data", data_out, 16'h0000);
        check("rst_drop", drop_count, 8'd0);
        #1 reset = 1'b0;
        tick();

        // Single word, 3-cycle latency with pop[1] held.
        pop = 2'b10;
        push_word(8'hAB, 1'b0, 1'b1);
        check("sw_vc_nonempty", vc_empty[0], 1'b0);
        tick();
        check("sw_k1_valid", valid_out, 2'b00);
        check("sw_k1_d_empty", d_empty, 2'b01);
        tick();
        check("sw_k2_valid", valid_out, 2'b10);
        check("sw_k2_data", data_out, 16'hAB00);
        tick();
        check("sw_k3_valid", valid_out, 2'b00);
        check("sw_k3_hold", data_out, 16'hAB00);
        check("sw_k3_d_empty", d_empty, 2'b11);
        pop = 2'b00;

        // Strict-priority arbitration.
        pulse_reset();
        arb_mode = 1'b0; af_d = 5'd1;
        push_word(8'h10, 1'b0, 1'b0); push_word(8'h20, 1'b1, 1'b0);
        push_word(8'h11, 1'b0, 1'b0); push_word(8'h21, 1'b1, 1'b0);
        push_word(8'h12, 1'b0, 1'b0); push_word(8'h22, 1'b1, 1'b0);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        drain_d0("arb_strict");

        // Round-robin arbitration.
        pulse_reset();
        arb_mode = 1'b1;
        push_word(8'h10, 1'b0, 1'b0); push_word(8'h20, 1'b1, 1'b0);
        push_word(8'h11, 1'b0, 1'b0); push_word(8'h21, 1'b1, 1'b0);
        push_word(8'h12, 1'b0, 1'b0); push_word(8'h22, 1'b1, 1'b0);
        exp_q = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        drain_d0("arb_rr");
        arb_mode = 1'b0;

        // Overflow: one word moves to dest 0, eight fill VC0, tenth is dropped.
        pulse_reset();
        af_vc = 5'd6; af_d = 5'd1;
        for (int i = 0; i < 10; i++) push_word(8'(i), 1'b0, 1'b0);
        check("ovf_drop", drop_count, 8'd1);
        check("ovf_vc_af", vc_almost_full, 2'b01);
        check("ovf_vc_empty", vc_empty, 2'b10);
        check("ovf_vc_ae", vc_almost_empty, 2'b10);
        check("ovf_d_af", d_almost_full, 2'b01);
        check("ovf_d_empty", d_empty, 2'b10);
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        drain_d0("ovf_order");

        // Pop on empty, then drop counter saturation.
        pulse_reset();
        pop = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pe_valid", valid_out, 2'b00);
            check("pe_data", data_out, 16'h0000);
            check("pe_d_empty", d_empty, 2'b11);
        end
        pop = 2'b00;
        for (int i = 0; i < 9; i++) push_word(8'h77, 1'b0, 1'b0);
        check("sat_drop0", drop_count, 8'd0);
        for (int i = 0; i < 254; i++) push_word(8'h77, 1'b0, 1'b0);
        check("sat_drop254", drop_count, 8'd254);
        for (int i = 0; i < 46; i++) push_word(8'h77, 1'b0, 1'b0);
        check("sat_drop255", drop_count, 8'd255);

        // Reset mid-operation with five words queued.
        pulse_reset();
        check("mid_drop_cleared", drop_count, 8'd0);
        for (int i = 0; i < 5; i++) push_word(8'hC0 + 8'(i), 1'b0, 1'b0);
        check("mid_queued", vc_empty, 2'b10);
        reset = 1'b1;
        #1;
        check("mid_vc_empty", vc_empty, 2'b11);
        check("mid_d_empty", d_empty, 2'b11);
        reset = 1'b0;
        pop = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", valid_out, 2'b00);
        end
        pop = 2'b01;
        push_word(8'h5A, 1'b1, 1'b0);
        tick();
        check("mid_k1_valid", valid_out, 2'b00);
        tick();
        check("mid_k2_valid", valid_out, 2'b01);
        check("mid_k2_data", data_out[7:0], 8'h5A);
        pop = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
